game_tick_scheduler: RTL and testbench

GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

---
 rtl/game_tick_scheduler_pkg.sv | 25 ++
 rtl/game_tick_scheduler_tick_prescaler.sv | 39 +++
 rtl/game_tick_scheduler.sv | 150 +++++++++++++++
 tb/tb_game_tick_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/game_tick_scheduler_pkg.sv
// Shared game constants: state encoding, state width and level limits.
package game_tick_scheduler_pkg;

  localparam int STATE_W = 2;
  localparam logic [2:0] LEVEL_MAX = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } game_state_t;

  // Increment a difficulty level, sticking at LEVEL_MAX.
  function automatic logic [2:0] level_sat_inc(input logic [2:0] lvl);
    logic [2:0] nxt;
    if (lvl == LEVEL_MAX) begin
      nxt = LEVEL_MAX;
    end else begin
      nxt = lvl + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_prescaler.sv
// Game-tick prescaler: counts 0..DIV-1 while enabled, flags the last count.
module tick_prescaler #(
  parameter int              DIV_W = 20,
  parameter logic [DIV_W-1:0] DIV  = 20'd833333
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [DIV_W-1:0] count,
  output logic             wrap
);

  localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] LAST = DIV - ONE;

  logic [DIV_W-1:0] r_count;

  // Count while enabled, hold otherwise; clear has priority over counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {DIV_W{1'b0}};
    end else if (clr) begin
      r_count <= {DIV_W{1'b0}};
    end else if (en) begin
      if (r_count == LAST) begin
        r_count <= {DIV_W{1'b0}};
      end else begin
        r_count <= r_count + ONE;
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;
  assign wrap  = en & (r_count == LAST);

endmodule

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: game state machine, tick/pipe-spawn pulses and level.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int               DIV_W      = 20,
  parameter logic [DIV_W-1:0] DIV        = 20'd833333,
  parameter logic [7:0]       PIPE_EVERY = 8'd90,
  parameter logic [7:0]       LVL_UP     = 8'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       collision,
  output logic       tick_o,
  output logic       pipe_spawn_o,
  output logic [2:0] level_o,
  output logic [1:0] state_o
);

  localparam logic [DIV_W-1:0] ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] LAST = DIV - ONE;

  game_state_t      r_state;
  logic             r_start_prev;
  logic             r_start_arm;
  logic             r_pause_prev;
  logic [7:0]       r_pipe_cnt;
  logic [7:0]       r_spawn_cnt;
  logic [2:0]       r_level;

  logic             w_start_req;
  logic             w_pause_req;
  logic             w_clr;
  logic             w_run;
  logic             w_wrap;
  logic [DIV_W-1:0] w_presc_cnt;
  logic             w_tick;
  logic             w_spawn;

  // start only counts once it has been seen low since reset, so a button
  // held through reset release needs a fresh press.
  assign w_start_req = start & ~r_start_prev & r_start_arm;
  assign w_pause_req = pause & ~r_pause_prev;
  assign w_run       = (r_state == ST_RUN);

  // Counter clear on entry to RUN from IDLE or OVER (not on resume from pause).
  always_comb begin
    w_clr = 1'b0;
    case (r_state)
      ST_IDLE: w_clr = w_start_req;
      ST_OVER: w_clr = w_start_req;
      default: w_clr = 1'b0;
    endcase
  end

  tick_prescaler #(
    .DIV_W (DIV_W),
    .DIV   (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_run),
    .count (w_presc_cnt),
    .wrap  (w_wrap)
  );

  // wrap is cross-qualified by the observed count as a consistency guard.
  assign w_tick  = w_wrap & (w_presc_cnt == LAST);
  assign w_spawn = w_tick & (r_pipe_cnt == (PIPE_EVERY - 8'd1));

  // Button edge-detect registers and the start re-arm flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
      r_start_arm  <= 1'b0;
    end else begin
      r_start_prev <= start;
      r_pause_prev <= pause;
      if (!start) begin
        r_start_arm <= 1'b1;
      end else begin
        r_start_arm <= r_start_arm;
      end
    end
  end

  // Game state machine; collision outranks pause in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   r_state <= w_start_req ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (collision) begin
            r_state <= ST_OVER;
          end else if (w_pause_req) begin
            r_state <= ST_PAUSED;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_PAUSED: r_state <= w_pause_req ? ST_RUN : ST_PAUSED;
        ST_OVER:   r_state <= w_start_req ? ST_RUN : ST_OVER;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Pipe, spawn and level counters; they only move on ticks, which only occur in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_cnt  <= 8'd0;
      r_spawn_cnt <= 8'd0;
      r_level     <= 3'd0;
    end else if (w_clr) begin
      r_pipe_cnt  <= 8'd0;
      r_spawn_cnt <= 8'd0;
      r_level     <= 3'd0;
    end else if (w_tick) begin
      if (w_spawn) begin
        r_pipe_cnt <= 8'd0;
        if (r_spawn_cnt == (LVL_UP - 8'd1)) begin
          r_spawn_cnt <= 8'd0;
          r_level     <= level_sat_inc(r_level);
        end else begin
          r_spawn_cnt <= r_spawn_cnt + 8'd1;
          r_level     <= r_level;
        end
      end else begin
        r_pipe_cnt  <= r_pipe_cnt + 8'd1;
        r_spawn_cnt <= r_spawn_cnt;
        r_level     <= r_level;
      end
    end else begin
      r_pipe_cnt  <= r_pipe_cnt;
      r_spawn_cnt <= r_spawn_cnt;
      r_level     <= r_level;
    end
  end

  assign tick_o       = w_tick;
  assign pipe_spawn_o = w_spawn;
  assign level_o      = r_level;
  assign state_o      = r_state;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed scoreboard bench for game_tick_scheduler (DIV=4, PIPE_EVERY=3, LVL_UP=2).
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic       collision;
  logic       tick_o;
  logic       pipe_spawn_o;
  logic [2:0] level_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic       tick;
    logic       spawn;
    logic [1:0] state;
    logic [2:0] level;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  game_tick_scheduler #(
    .DIV_W      (20),
    .DIV        (20'd4),
    .PIPE_EVERY (8'd3),
    .LVL_UP     (8'd2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pause        (pause),
    .collision    (collision),
    .tick_o       (tick_o),
    .pipe_spawn_o (pipe_spawn_o),
    .level_o      (level_o),
    .state_o      (state_o)
  );

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic push(input logic t, input logic s, input logic [1:0] st,
                      input logic [2:0] lv, input string tag);
    exp_t e;
    e.tick = t; e.spawn = s; e.state = st; e.level = lv;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Level expected during RUN cycle k of a fresh game: one step per 24 cycles, max 7.
  function automatic logic [2:0] lvl(input int k);
    int v;
    v = (k - 1) / 24;
    if (v > 7) v = 7;
    return v[2:0];
  endfunction

  task automatic push_run(input int k0, input int n, input string tag);
    for (int k = k0; k < k0 + n; k++) begin
      push((k % 4) == 0, (k % 12) == 0, 2'd1, lvl(k), $sformatf("%s_k%0d", tag, k));
    end
  endtask

  task automatic check_one();
    exp_t  e;
    string tg;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL sb_underflow observed=empty expected=record");
    end else begin
      e  = sb_q.pop_front();
      tg = tag_q.pop_front();
      chk({tg, "_state"}, {6'd0, state_o}, {6'd0, e.state});
      chk({tg, "_tick"},  {7'd0, tick_o}, {7'd0, e.tick});
      chk({tg, "_spawn"}, {7'd0, pipe_spawn_o}, {7'd0, e.spawn});
      chk({tg, "_level"}, {5'd0, level_o}, {5'd0, e.level});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; pause = 1'b0; collision = 1'b0;
    #2 rst = 1'b0;

    // Reset state, start held high throughout.
    repeat (3) cyc();
    push(1'b0, 1'b0, 2'd0, 3'd0, "reset");
    check_one();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      push(1'b0, 1'b0, 2'd0, 3'd0, "held_start");
      check_one();
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      push(1'b0, 1'b0, 2'd0, 3'd0, "start_low");
      check_one();
    end

    // Game 1: start, run to cycle 32, collision+pause together in a tick cycle.
    start = 1'b1;
    push(1'b0, 1'b0, 2'd0, 3'd0, "press");
    check_one();
    push_run(1, 32, "g1");
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k == 1) start = 1'b0;
      if (k == 32) begin
        collision = 1'b1;
        pause     = 1'b1;
        for (int i = 0; i < 6; i++) push(1'b0, 1'b0, 2'd3, 3'd1, "over1");
      end
      check_one();
    end
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i == 1) begin collision = 1'b0; pause = 1'b0; end
      if (i == 6) begin start = 1'b1; push_run(1, 200, "g2"); end
      check_one();
    end

    // Game 2: cleared counters, long run to level saturation, then collision.
    for (int k = 1; k <= 200; k++) begin
      cyc();
      if (k == 1) start = 1'b0;
      if (k == 200) begin
        collision = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 2'd3, 3'd7, "over2");
      end
      check_one();
    end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i == 1) collision = 1'b0;
      if (i == 3) begin
        start = 1'b1;
        push_run(1, 2, "g3a");
        for (int j = 0; j < 10; j++) push(1'b0, 1'b0, 2'd2, 3'd0, "paused");
        push_run(3, 12, "g3b");
      end
      check_one();
    end

    // Game 3: pause at RUN cycle 2, collision ignored while paused, resume.
    for (int j = 1; j <= 24; j++) begin
      cyc();
      case (j)
        1:  start = 1'b0;
        2:  pause = 1'b1;
        3:  pause = 1'b0;
        5:  collision = 1'b1;
        7:  collision = 1'b0;
        12: pause = 1'b1;
        13: pause = 1'b0;
        default: ;
      endcase
      check_one();
    end

    // Asynchronous reset mid-cycle during RUN.
    cyc();
    #2 rst = 1'b0;
    #1;
    push(1'b0, 1'b0, 2'd0, 3'd0, "async_rst");
    check_one();
    cyc();
    push(1'b0, 1'b0, 2'd0, 3'd0, "in_rst");
    check_one();

    chk("sb_empty", sb_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
